// File: rtl/preamble_peak_trigger_pkg.sv
// Shared state encodings and default widths for the preamble peak trigger.
package preamble_peak_trigger_pkg;
  localparam int MAG_W_DEF  = 28;
  localparam int FRAC_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int IDX_W_DEF  = 32;
  localparam int RUN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SEARCH  = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;
endpackage

// File: rtl/preamble_peak_trigger_thres.sv
// Stage 1: threshold multiply, qualify compares and a valid/ready register slice.
module pd_thres_stage
  import preamble_peak_trigger_pkg::*;
#(
  parameter int MAG_WIDTH  = MAG_W_DEF,
  parameter int FRAC_WIDTH = FRAC_W_DEF,
  parameter int IDX_WIDTH  = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [FRAC_WIDTH-1:0] thres_frac,
  input  logic [MAG_WIDTH-1:0]  noise_pow,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [MAG_WIDTH-1:0]  in_pmag,
  input  logic [MAG_WIDTH-1:0]  in_acmag,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  output logic                  s1_valid,
  input  logic                  s1_ready,
  output logic                  s1_last,
  output logic                  s1_qual,
  output logic [MAG_WIDTH-1:0]  s1_acmag,
  output logic [IDX_WIDTH-1:0]  s1_idx
);
  localparam int PROD_W = MAG_WIDTH + FRAC_WIDTH;

  logic [PROD_W-1:0]    prod;
  logic [MAG_WIDTH-1:0] thr;
  logic                 qual;
  logic                 ready_en;

  // Full-width product; the threshold is the truncated upper slice, never clipped.
  assign prod     = PROD_W'(in_pmag) * PROD_W'(thres_frac);
  assign thr      = MAG_WIDTH'(prod >> FRAC_WIDTH);
  assign qual     = (in_acmag > thr) & (in_pmag > noise_pow) & (in_acmag > noise_pow);
  assign in_ready = ready_en & (~s1_valid | s1_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_qual  <= 1'b0;
      s1_acmag <= '0;
      s1_idx   <= '0;
    end else if (clear) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_qual  <= 1'b0;
      s1_acmag <= '0;
      s1_idx   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_last  <= in_last;
        s1_qual  <= qual;
        s1_acmag <= in_acmag;
        s1_idx   <= in_idx;
      end else if (s1_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/preamble_peak_trigger.sv
// Programmable preamble peak trigger: run-length qualify, windowed peak search, hold-off.
// Handshakes: a beat transfers on any rising clk edge where valid & ready are both high;
// valid never waits on ready, and out_tdata is held stable while out_tvalid is high.
module preamble_peak_trigger
  import preamble_peak_trigger_pkg::*;
#(
  parameter int MAG_WIDTH  = MAG_W_DEF,
  parameter int FRAC_WIDTH = FRAC_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF,
  parameter int IDX_WIDTH  = IDX_W_DEF,
  parameter int RUN_WIDTH  = RUN_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           cfg_enable,
  input  logic [FRAC_WIDTH-1:0]          cfg_thres_frac,
  input  logic [MAG_WIDTH-1:0]           cfg_noise_pow,
  input  logic [RUN_WIDTH-1:0]           cfg_min_run,
  input  logic [CNT_WIDTH-1:0]           cfg_search_len,
  input  logic [CNT_WIDTH-1:0]           cfg_holdoff,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  input  logic                           in_tlast,
  input  logic [MAG_WIDTH-1:0]           in_pmag,
  input  logic [MAG_WIDTH-1:0]           in_acmag,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic                           out_tlast,
  output logic [IDX_WIDTH+MAG_WIDTH-1:0] out_tdata,
  output logic                           peak_stb,
  output logic [2:0]                     state_dbg
);
  state_e                state;
  logic [IDX_WIDTH-1:0]  idx_cnt, max_idx, s1_idx, nxt_idx;
  logic [MAG_WIDTH-1:0]  max_mag, s1_acmag, nxt_mag, lat_noise, stg_noise;
  logic [FRAC_WIDTH-1:0] lat_frac, stg_frac;
  logic [RUN_WIDTH-1:0]  run_cnt, run_nxt, lat_min_run, min_run_eff;
  logic [CNT_WIDTH-1:0]  count, cnt_inc, lat_search, search_eff, lat_holdoff;
  logic                  s1_valid, s1_last, s1_qual, stall, beat, new_max;

  // While idle the stage sees live config so the beat seen on the latch cycle matches.
  assign stg_frac    = (state == ST_IDLE) ? cfg_thres_frac : lat_frac;
  assign stg_noise   = (state == ST_IDLE) ? cfg_noise_pow : lat_noise;
  assign stall       = out_tvalid & ~out_tready;
  assign beat        = s1_valid & ~stall;
  assign min_run_eff = (lat_min_run == '0) ? RUN_WIDTH'(1) : lat_min_run;
  assign search_eff  = (lat_search == '0) ? CNT_WIDTH'(1) : lat_search;
  assign run_nxt     = !s1_qual ? '0 : ((&run_cnt) ? run_cnt : run_cnt + RUN_WIDTH'(1));
  assign cnt_inc     = count + CNT_WIDTH'(1);
  assign new_max     = s1_acmag > max_mag;
  assign nxt_mag     = new_max ? s1_acmag : max_mag;
  assign nxt_idx     = new_max ? s1_idx : max_idx;
  assign out_tlast   = 1'b1;
  assign state_dbg   = state;

  pd_thres_stage #(
    .MAG_WIDTH (MAG_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_thres (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .thres_frac(stg_frac),
    .noise_pow (stg_noise),
    .in_valid  (in_tvalid),
    .in_ready  (in_tready),
    .in_last   (in_tlast),
    .in_pmag   (in_pmag),
    .in_acmag  (in_acmag),
    .in_idx    (idx_cnt),
    .s1_valid  (s1_valid),
    .s1_ready  (~stall),
    .s1_last   (s1_last),
    .s1_qual   (s1_qual),
    .s1_acmag  (s1_acmag),
    .s1_idx    (s1_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      idx_cnt <= '0;
    else if (clear)                    idx_cnt <= '0;
    else if (in_tvalid && in_tready)   idx_cnt <= idx_cnt + IDX_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;  run_cnt <= '0;  count <= '0;  max_mag <= '0;  max_idx <= '0;
      lat_frac <= '0;  lat_noise <= '0;  lat_min_run <= '0;  lat_search <= '0;
      lat_holdoff <= '0;  out_tvalid <= 1'b0;  out_tdata <= '0;  peak_stb <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;  run_cnt <= '0;  count <= '0;  max_mag <= '0;  max_idx <= '0;
      lat_frac <= '0;  lat_noise <= '0;  lat_min_run <= '0;  lat_search <= '0;
      lat_holdoff <= '0;  out_tvalid <= 1'b0;  out_tdata <= '0;  peak_stb <= 1'b0;
    end else begin
      peak_stb <= 1'b0;
      case (state)
        ST_IDLE: if (cfg_enable) begin
          lat_frac    <= cfg_thres_frac;
          lat_noise   <= cfg_noise_pow;
          lat_min_run <= cfg_min_run;
          lat_search  <= cfg_search_len;
          lat_holdoff <= cfg_holdoff;
          run_cnt     <= '0;
          state       <= ST_ARMED;
        end
        ST_ARMED: if (!cfg_enable) begin
          state <= ST_IDLE;
        end else if (beat) begin
          run_cnt <= run_nxt;
          if (run_nxt >= min_run_eff) begin
            max_mag <= s1_acmag;
            max_idx <= s1_idx;
            count   <= CNT_WIDTH'(1);
            // A one-beat window or an end-of-burst trigger beat reports immediately.
            if (search_eff == CNT_WIDTH'(1) || s1_last) begin
              out_tdata  <= {s1_idx, s1_acmag};
              out_tvalid <= 1'b1;
              peak_stb   <= 1'b1;
              state      <= ST_REPORT;
            end else begin
              state <= ST_SEARCH;
            end
          end
        end
        ST_SEARCH: if (!cfg_enable) begin
          state <= ST_IDLE;
        end else if (beat) begin
          max_mag <= nxt_mag;
          max_idx <= nxt_idx;
          count   <= cnt_inc;
          if (cnt_inc >= search_eff || s1_last) begin
            out_tdata  <= {nxt_idx, nxt_mag};
            out_tvalid <= 1'b1;
            peak_stb   <= 1'b1;
            state      <= ST_REPORT;
          end
        end
        ST_REPORT: if (out_tready) begin
          out_tvalid <= 1'b0;
          count      <= '0;
          run_cnt    <= '0;
          if (!cfg_enable)              state <= ST_IDLE;
          else if (lat_holdoff == '0)   state <= ST_ARMED;
          else                          state <= ST_HOLDOFF;
        end
        ST_HOLDOFF: if (!cfg_enable) begin
          state <= ST_IDLE;
        end else if (beat) begin
          count <= cnt_inc;
          if (cnt_inc >= lat_holdoff) begin
            run_cnt <= '0;
            state   <= ST_ARMED;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
